// File: rtl/mem_arbiter_pkg.sv
// Shared encodings, defaults and sizing helper for the instruction/data memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      PORT_DATA  = 1'b0,
      PORT_FETCH = 1'b1
   } port_t;

   localparam int DEF_AW         = 13;
   localparam int DEF_DW         = 13;
   localparam int DEF_MAX_STREAK = 3;
   localparam int DEF_TIMEOUT    = 15;

   // Bits needed to hold 0..max_val; never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_priority.sv
// Grant selection between fetch and data requesters, with the fetch anti-starvation streak counter.
module mem_arbiter_priority
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_STREAK = DEF_MAX_STREAK
)
(
   input  logic  clk,
   input  logic  reset,
   input  logic  arb_en,
   input  logic  if_req,
   input  logic  d_req,
   output logic  grant,
   output port_t grant_port
);

   localparam int            SW         = cnt_width(MAX_STREAK);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

   logic [SW-1:0] streak;
   logic          fetch_due;

   always_comb begin
      fetch_due  = if_req && (streak == STREAK_MAX);
      grant      = arb_en && (if_req || d_req);
      grant_port = (fetch_due || !d_req) ? PORT_FETCH : PORT_DATA;
   end

   // Only data grants that actually bypass a waiting fetch count towards the streak.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         streak <= '0;
      end else if (arb_en) begin
         if (!if_req || (grant && (grant_port == PORT_FETCH))) begin
            streak <= '0;
         end else if (grant && (streak != STREAK_MAX)) begin
            streak <= streak + SW'(1);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto the single-ported main memory with a Done timeout.
//
//   state | meaning
//   IDLE  | arbitrate pending requests, latch the winner's fields
//   ISSUE | one-cycle read/write strobe, Done already sampled
//   WAIT  | strobes low, waiting for Done or timeout
//   RESP  | one-cycle ack (and timeout_err) to the granted port
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW         = DEF_AW,
   parameter int DW         = DEF_DW,
   parameter int MAX_STREAK = DEF_MAX_STREAK,
   parameter int TIMEOUT    = DEF_TIMEOUT
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_dataIn,
   output logic          mem_write,
   output logic          mem_read,
   output logic          mem_instruction,
   input  logic [DW-1:0] mem_dataOut,
   input  logic          mem_Done,
   output logic          busy,
   output logic          timeout_err
);

   localparam int            TW       = cnt_width(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t        state, state_d;
   port_t         lat_port, lat_port_d;
   logic          lat_we, lat_we_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] wdata_d;
   logic [TW-1:0] tmo_cnt, tmo_cnt_d;

   logic          grant;
   port_t         grant_port;
   logic          capture, tmo_hit;
   logic          if_ack_d, d_ack_d, tmo_err_d;
   logic          read_d, write_d, instr_d, busy_d;
   logic [DW-1:0] if_rdata_d, d_rdata_d;

   mem_arbiter_priority #(
      .MAX_STREAK (MAX_STREAK)
   ) u_priority (
      .clk        (clk),
      .reset      (reset),
      .arb_en     (state == IDLE),
      .if_req     (if_req),
      .d_req      (d_req),
      .grant      (grant),
      .grant_port (grant_port)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d    = state;
      lat_port_d = lat_port;
      lat_we_d   = lat_we;
      addr_d     = mem_address;
      wdata_d    = mem_dataIn;
      tmo_cnt_d  = '0;
      capture    = 1'b0;
      tmo_hit    = 1'b0;
      read_d     = 1'b0;
      write_d    = 1'b0;
      instr_d    = 1'b0;

      case (state)
         IDLE: begin
            if (grant) begin
               state_d    = ISSUE;
               lat_port_d = grant_port;
               if (grant_port == PORT_FETCH) begin
                  lat_we_d = 1'b0;
                  addr_d   = if_addr;
                  wdata_d  = '0;
               end else begin
                  lat_we_d = d_we;
                  addr_d   = d_addr;
                  wdata_d  = d_wdata;
               end
               read_d  = !lat_we_d;
               write_d = lat_we_d;
               instr_d = (grant_port == PORT_FETCH);
            end
         end
         ISSUE: begin
            if (mem_Done) begin
               state_d = RESP;
               capture = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_Done) begin
               state_d = RESP;
               capture = 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
               state_d = RESP;
               tmo_hit = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt + TW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      busy_d     = (state_d != IDLE);
      if_ack_d   = (state_d == RESP) && (lat_port == PORT_FETCH);
      d_ack_d    = (state_d == RESP) && (lat_port == PORT_DATA);
      tmo_err_d  = tmo_hit;
      if_rdata_d = (capture && (lat_port == PORT_FETCH)) ? mem_dataOut : '0;
      d_rdata_d  = (capture && (lat_port == PORT_DATA) && !lat_we) ? mem_dataOut : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_port        <= PORT_DATA;
         lat_we          <= 1'b0;
         tmo_cnt         <= '0;
         mem_address     <= '0;
         mem_dataIn      <= '0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_instruction <= 1'b0;
         if_ack          <= 1'b0;
         d_ack           <= 1'b0;
         if_rdata        <= '0;
         d_rdata         <= '0;
         busy            <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         lat_port        <= lat_port_d;
         lat_we          <= lat_we_d;
         tmo_cnt         <= tmo_cnt_d;
         mem_address     <= addr_d;
         mem_dataIn      <= wdata_d;
         mem_read        <= read_d;
         mem_write       <= write_d;
         mem_instruction <= instr_d;
         if_ack          <= if_ack_d;
         d_ack           <= d_ack_d;
         if_rdata        <= if_rdata_d;
         d_rdata         <= d_rdata_d;
         busy            <= busy_d;
         timeout_err     <= tmo_err_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural memory with programmable Done delay.
module tb_mem_arbiter;

   localparam int AW         = 13;
   localparam int DW         = 13;
   localparam int MAX_STREAK = 3;
   localparam int TIMEOUT    = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] if_rdata, d_rdata;
   logic          if_ack, d_ack;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_dataIn, mem_dataOut;
   logic          mem_write, mem_read, mem_instruction, mem_Done;
   logic          busy, timeout_err;

   always #5 clk = ~clk;

   mem_arbiter #(
      .AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .if_req          (if_req),
      .if_addr         (if_addr),
      .if_rdata        (if_rdata),
      .if_ack          (if_ack),
      .d_req           (d_req),
      .d_we            (d_we),
      .d_addr          (d_addr),
      .d_wdata         (d_wdata),
      .d_rdata         (d_rdata),
      .d_ack           (d_ack),
      .mem_address     (mem_address),
      .mem_dataIn      (mem_dataIn),
      .mem_write       (mem_write),
      .mem_read        (mem_read),
      .mem_instruction (mem_instruction),
      .mem_dataOut     (mem_dataOut),
      .mem_Done        (mem_Done),
      .busy            (busy),
      .timeout_err     (timeout_err)
   );

   typedef struct packed {
      logic          fetch;
      logic [DW-1:0] rdata;
      logic          tmo;
   } sb_t;

   sb_t           sb_q[$];
   sb_t           sb_e;
   logic          glog[$];
   logic [DW-1:0] mem_arr [0:(1<<AW)-1];

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   int            done_delay = -1;
   int            rd_cycles = 0, wr_cycles = 0, busy_cycles = 0;
   int            wcnt = 0;
   logic          pending;
   logic          last_instr;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_wdata;

   assign mem_dataOut = mem_arr[mem_address];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: Done is raised done_delay cycles after the ISSUE strobe (negative = never).
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_arr[i] = DW'(i * 7 + 3);
      mem_arr[5]     = 13'h0F0;
      mem_arr[13'h10] = 13'h1F0F;
      pending  = 1'b0;
      mem_Done = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            pending  = 1'b0;
            mem_Done = 1'b0;
         end else begin
            if (mem_read || mem_write) begin
               pending    = 1'b1;
               wcnt       = 0;
               glog.push_back(mem_instruction);
               last_instr = mem_instruction;
               last_addr  = mem_address;
               last_wdata = mem_dataIn;
               if (mem_write) mem_arr[mem_address] = mem_dataIn;
            end else if (pending) begin
               wcnt++;
            end
            if (if_ack || d_ack) pending = 1'b0;
            mem_Done     = pending && (wcnt == done_delay);
            rd_cycles   += int'(mem_read);
            wr_cycles   += int'(mem_write);
            busy_cycles += int'(busy);
         end
      end
   end

   always @(negedge clk) begin
      if (timeout_err && !(if_ack || d_ack)) check_val("tmo_err_without_ack", 1'b1, 1'b0);
      if (if_ack || d_ack) begin
         check_val("ack_exclusive", if_ack & d_ack, 1'b0);
         if (sb_q.size() == 0) begin
            check_val("ack_unexpected", 1'b1, 1'b0);
         end else begin
            sb_e = sb_q.pop_front();
            check_val("ack_port", if_ack, sb_e.fetch);
            check_val("ack_rdata", if_ack ? if_rdata : d_rdata, sb_e.rdata);
            check_val("ack_tmo_err", timeout_err, sb_e.tmo);
            check_val("ack_busy", busy, 1'b1);
         end
      end
   end

   task automatic run_req(input string tag, input logic is_fetch, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int delay);
      sb_t  e;
      int   t0, lat_exp, rd0, wr0, b0;
      logic got, tmo;
      tmo     = (delay < 0) || (delay > TIMEOUT);
      lat_exp = tmo ? TIMEOUT + 2 : 2 + delay;
      e.fetch = is_fetch;
      e.tmo   = tmo;
      e.rdata = (tmo || we) ? '0 : mem_arr[addr];
      done_delay = delay;
      @(posedge clk); #1;
      rd0 = rd_cycles; wr0 = wr_cycles; b0 = busy_cycles;
      sb_q.push_back(e);
      if (is_fetch) begin
         if_req  = 1'b1;
         if_addr = addr;
      end else begin
         d_req   = 1'b1;
         d_we    = we;
         d_addr  = addr;
         d_wdata = wdata;
      end
      t0  = cyc;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (is_fetch ? if_ack : d_ack) begin
            got = 1'b1;
            break;
         end
      end
      check_val({tag, "_ack_seen"}, got, 1'b1);
      check_val({tag, "_latency"}, 64'(cyc - t0), 64'(lat_exp));
      @(posedge clk); #1;
      if_req = 1'b0;
      d_req  = 1'b0;
      check_val({tag, "_read_pulses"}, 64'(rd_cycles - rd0), {63'd0, !we});
      check_val({tag, "_write_pulses"}, 64'(wr_cycles - wr0), {63'd0, we});
      check_val({tag, "_busy_cycles"}, 64'(busy_cycles - b0), 64'(lat_exp));
      check_val({tag, "_instruction"}, last_instr, is_fetch);
      check_val({tag, "_address"}, last_addr, addr);
      if (we) check_val({tag, "_dataIn"}, last_wdata, wdata);
      check_val({tag, "_idle_after"}, busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] pat;
      int         n_ack;
      reset = 1'b0;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      #2;
      check_val("reset_outputs", {if_rdata, if_ack, d_rdata, d_ack, mem_address, mem_dataIn,
                                  mem_write, mem_read, mem_instruction, busy, timeout_err}, '0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      run_req("load_done2", 1'b0, 1'b0, 13'd5, 13'd0, 2);
      run_req("store", 1'b0, 1'b1, 13'd3, 13'h1ABC, 1);
      run_req("load_back", 1'b0, 1'b0, 13'd3, 13'd0, 0);
      run_req("fetch", 1'b1, 1'b0, 13'h0010, 13'd0, 1);

      // Both requesters held: data wins three times, then fetch is forced in.
      done_delay = 0;
      glog.delete();
      pat = 8'b1000_1000;
      for (int i = 0; i < 8; i++) begin
         sb_e.fetch = pat[i];
         sb_e.rdata = pat[i] ? mem_arr[13'h20] : mem_arr[13'h30];
         sb_e.tmo   = 1'b0;
         sb_q.push_back(sb_e);
      end
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 13'h20;
      d_req  = 1'b1; d_we = 1'b0; d_addr = 13'h30;
      n_ack = 0;
      for (int i = 0; i < 300 && n_ack < 8; i++) begin
         @(negedge clk);
         if (if_ack || d_ack) n_ack++;
      end
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0;
      check_val("streak_acks", 64'(n_ack), 64'd8);
      check_val("streak_grants", 64'(glog.size()), 64'd8);
      for (int i = 0; i < 8 && i < glog.size(); i++)
         check_val($sformatf("grant_order_%0d", i), glog[i], pat[i]);

      run_req("timeout", 1'b0, 1'b0, 13'd7, 13'd0, -1);

      // Reset pulled while the access sits in WAIT: no ack may follow.
      done_delay = -1;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 13'd9;
      repeat (4) @(posedge clk);
      #1 check_val("pre_reset_busy", busy, 1'b1);
      #2 reset = 1'b0;
      #1;
      check_val("midreset_outputs", {if_rdata, if_ack, d_rdata, d_ack, mem_address, mem_dataIn,
                                     mem_write, mem_read, mem_instruction, busy, timeout_err}, '0);
      d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      run_req("after_reset", 1'b0, 1'b0, 13'h10, 13'd0, 3);

      repeat (3) @(posedge clk);
      check_val("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
